// File: rtl/stream_min_max.sv
// Streaming min/max reduction over a frame of samples with index tracking.
// Define STREAM_MIN_MAX_SIGNED_CMP_EN for two's-complement comparison.
module stream_min_max #(
  parameter int N     = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [N:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N:0]       min_out,
  output logic [N:0]       max_out,
  output logic [LEN_W-1:0] min_idx,
  output logic [LEN_W-1:0] max_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic             accept;
  logic             last;
  logic             new_min;
  logic             new_max;

  function automatic logic lt(
    input logic [N:0] a,
    input logic [N:0] b
  );
`ifdef STREAM_MIN_MAX_SIGNED_CMP_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Handshake and compare decode for the current sample
  always_comb begin
    accept  = in_valid & in_ready;
    last    = accept && (count == len_q - LEN_W'(1));
    new_min = lt(in_data, min_out);
    new_max = lt(max_out, in_data);
  end

  // Frame FSM with registered results and status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len_q    <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      min_out  <= '0;
      max_out  <= '0;
      min_idx  <= '0;
      max_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            len_q <= frame_len;
            count <= '0;
            busy  <= 1'b1;
            if (frame_len != '0) begin
              state    <= RUN;
              in_ready <= 1'b1;
            end else begin
              state   <= DONE;
              done    <= 1'b1;
              min_out <= '0;
              max_out <= '0;
              min_idx <= '0;
              max_idx <= '0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            count <= count + LEN_W'(1);
            if (count == '0) begin
              min_out <= in_data;
              max_out <= in_data;
              min_idx <= '0;
              max_idx <= '0;
            end else begin
              if (new_min) begin
                min_out <= in_data;
                min_idx <= count;
              end
              if (new_max) begin
                max_out <= in_data;
                max_idx <= count;
              end
            end
            if (last) begin
              state    <= DONE;
              in_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_min_max.sv
// Directed self-checking bench for stream_min_max.
// Expected results are hand-computed per frame.
module tb_stream_min_max;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] frame_len;
  logic [8:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] min_out;
  logic [8:0] max_out;
  logic [7:0] min_idx;
  logic [7:0] max_idx;
  logic       busy;
  logic       done;

  int n_tests;
  int n_fail;

  logic [8:0] smp [8];

  stream_min_max #(
    .N    (8),
    .LEN_W(8)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .frame_len(frame_len),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .min_out  (min_out),
    .max_out  (max_out),
    .min_idx  (min_idx),
    .max_idx  (max_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag,
                         input logic [8:0] emin, input logic [7:0] emin_i,
                         input logic [8:0] emax, input logic [7:0] emax_i);
    chkv({tag, ".min"},  32'(min_out), 32'(emin));
    chkv({tag, ".mini"}, 32'(min_idx), 32'(emin_i));
    chkv({tag, ".max"},  32'(max_out), 32'(emax));
    chkv({tag, ".maxi"}, 32'(max_idx), 32'(emax_i));
  endtask

  // Runs a frame from IDLE; returns in the cycle where done must be high.
  task automatic do_frame(input string tag, input int len,
                          input int stall_at, input int stall_cyc);
    start     = 1'b1;
    frame_len = 8'(len);
    tick();
    start = 1'b0;
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        for (int k = 0; k < stall_cyc; k++) begin
          chk1({tag, ".stall_rdy"}, in_ready, 1'b1);
          tick();
        end
      end
      in_data  = smp[i];
      in_valid = 1'b1;
      chk1({tag, ".rdy"}, in_ready, 1'b1);
      chk1({tag, ".early_done"}, done, 1'b0);
      tick();
    end
    in_valid = 1'b0;
    chk1({tag, ".done"}, done, 1'b1);
    chk1({tag, ".busy"}, busy, 1'b1);
    chk1({tag, ".rdy_off"}, in_ready, 1'b0);
  endtask

  task automatic end_pulse(input string tag);
    tick();
    chk1({tag, ".pulse"}, done, 1'b0);
    chk1({tag, ".idle"}, busy, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    for (int i = 0; i < 8; i++) smp[i] = '0;

    #12;
    chk_res("rst", 9'd0, 8'd0, 9'd0, 8'd0);
    chk1("rst.rdy", in_ready, 1'b0);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.done", done, 1'b0);
    reset_n = 1'b1;
    tick();
    tick();
    chk1("idle.rdy", in_ready, 1'b0);
    chk1("idle.done", done, 1'b0);

    smp[0] = 9'd50;
    smp[1] = 9'd10;
    smp[2] = 9'd200;
    smp[3] = 9'd10;
    do_frame("basic", 4, -1, 0);
    chk_res("basic", 9'd10, 8'd1, 9'd200, 8'd2);
    end_pulse("basic");

    do_frame("stall", 4, 2, 3);
    chk_res("stall", 9'd10, 8'd1, 9'd200, 8'd2);
    end_pulse("stall");

    do_frame("zero", 0, -1, 0);
    chk_res("zero", 9'd0, 8'd0, 9'd0, 8'd0);
    end_pulse("zero");

    smp[0] = 9'h17F;
    do_frame("one", 1, -1, 0);
    chk_res("one", 9'h17F, 8'd0, 9'h17F, 8'd0);
    end_pulse("one");

    start     = 1'b1;
    frame_len = 8'd5;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 9'd7;
    tick();
    in_data = 9'd9;
    tick();
    in_valid = 1'b0;
    chk_res("pre_rst", 9'd7, 8'd0, 9'd9, 8'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_res("mid_rst", 9'd0, 8'd0, 9'd0, 8'd0);
    chk1("mid_rst.rdy", in_ready, 1'b0);
    chk1("mid_rst.busy", busy, 1'b0);
    #3;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("post_rst.done", done, 1'b0);
      chk1("post_rst.rdy", in_ready, 1'b0);
    end

    smp[0] = 9'd3;
    smp[1] = 9'd1;
    smp[2] = 9'd2;
    do_frame("after_rst", 3, -1, 0);
    chk_res("after_rst", 9'd1, 8'd1, 9'd3, 8'd0);
    end_pulse("after_rst");

    smp[0] = 9'h001;
    smp[1] = 9'h1FF;
    smp[2] = 9'h0FF;
    do_frame("sign", 3, -1, 0);
`ifdef STREAM_MIN_MAX_SIGNED_CMP_EN
    chk_res("sign", 9'h1FF, 8'd1, 9'h0FF, 8'd2);
`else
    chk_res("sign", 9'h001, 8'd0, 9'h1FF, 8'd1);
`endif
    end_pulse("sign");

    smp[0] = 9'd5;
    smp[1] = 9'd5;
    smp[2] = 9'd9;
    smp[3] = 9'd9;
    smp[4] = 9'd2;
    smp[5] = 9'd2;
    do_frame("ties", 6, 1, 1);
    chk_res("ties", 9'd2, 8'd4, 9'd9, 8'd2);
    end_pulse("ties");

    tick();
    chk_res("hold", 9'd2, 8'd4, 9'd9, 8'd2);
    chk1("hold.done", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
